// File: rtl/serial_link_pkg.sv
// Shared types and elaboration helpers for the byte-serial <-> word bridge.
package serial_link_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT
    } tx_state_e;

    function automatic int unsigned beats(input int unsigned word_w, input int unsigned bus_w);
        return word_w / bus_w;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/serial_word_bridge_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head; a pop frees a slot for a same-cycle push.
module sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Empty FIFO presents zero so the head is defined straight out of reset.
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/serial_word_bridge.sv
// Byte-serial <-> word bridge: RX beat assembler into a FIFO, TX FIFO drained by a serialiser FSM.
module serial_word_bridge
    import serial_link_pkg::*;
#(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned BUS_W     = 8,
    parameter int unsigned RX_DEPTH  = 4,
    parameter int unsigned TX_DEPTH  = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  in_bus,
    input  logic              ard_data_ready,
    output logic              data_in_ready,
    output logic [BUS_W-1:0]  out_bus,
    output logic              data_out_ready,
    input  logic              ard_receive_ready,
    output logic              shift_done,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_valid,
    input  logic              rx_pop,
    input  logic [WORD_W-1:0] tx_word,
    input  logic              tx_push,
    output logic              tx_full,
    output logic              err_overflow,
    output logic              err_underflow
);
    localparam int unsigned BEATS = beats(WORD_W, BUS_W);
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if ((WORD_W % BUS_W) != 0 || !is_pow2(RX_DEPTH) || !is_pow2(TX_DEPTH) ||
        RX_DEPTH < 2 || TX_DEPTH < 2) begin : g_bad_params
        $error("serial_word_bridge: illegal WORD_W/BUS_W/depth parameters");
    end

    logic [CW-1:0]     r_rx_cnt;
    logic [WORD_W-1:0] r_rx_shift;
    logic [WORD_W-1:0] w_rx_word;
    logic [CW-1:0]     w_rx_slot;
    logic              w_rx_last;
    logic              w_rx_accept;
    logic              w_rx_full;
    logic              w_rx_empty;

    tx_state_e         r_state;
    tx_state_e         w_state_d;
    logic [WORD_W-1:0] r_tx_shift;
    logic [CW-1:0]     r_tx_cnt;
    logic [CW-1:0]     w_tx_slot;
    logic [WORD_W-1:0] w_tx_head;
    logic              w_tx_empty;
    logic              w_tx_full;
    logic              w_tx_pop;
    logic              w_tx_accept;
    logic              r_shift_done;
    logic              r_err_overflow;
    logic              r_err_underflow;

    // Only the last beat of a word needs FIFO space, so earlier beats are never stalled.
    assign w_rx_last     = (r_rx_cnt == LAST);
    assign data_in_ready = !(w_rx_last && w_rx_full);
    assign w_rx_accept   = ard_data_ready && data_in_ready;
    assign w_rx_slot     = MSB_FIRST ? (LAST - r_rx_cnt) : r_rx_cnt;

    always_comb begin
        w_rx_word = r_rx_shift;
        w_rx_word[w_rx_slot * BUS_W +: BUS_W] = in_bus;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
        end else if (w_rx_accept) begin
            r_rx_shift <= w_rx_word;
            r_rx_cnt   <= w_rx_last ? '0 : r_rx_cnt + CW'(1);
        end
    end

    sync_fifo #(
        .W     (WORD_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_rx_accept && w_rx_last),
        .i_data  (w_rx_word),
        .i_pop   (rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (rx_word)
    );

    assign rx_valid = !w_rx_empty;

    sync_fifo #(
        .W     (WORD_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (tx_push),
        .i_data  (tx_word),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head)
    );

    assign tx_full = w_tx_full;

    always_comb begin
        w_state_d   = r_state;
        w_tx_pop    = 1'b0;
        w_tx_accept = 1'b0;
        unique case (r_state)
            TX_IDLE: begin
                if (!w_tx_empty) begin
                    w_state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                w_tx_pop  = 1'b1;
                w_state_d = TX_SHIFT;
            end
            TX_SHIFT: begin
                w_tx_accept = ard_receive_ready;
                if (ard_receive_ready && r_tx_cnt == LAST) begin
                    w_state_d = w_tx_empty ? TX_IDLE : TX_LOAD;
                end
            end
            default: w_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= TX_IDLE;
            r_tx_shift   <= '0;
            r_tx_cnt     <= '0;
            r_shift_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_shift_done <= w_tx_accept && (r_tx_cnt == LAST);
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_cnt   <= '0;
            end else if (w_tx_accept && r_tx_cnt != LAST) begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end
    end

    assign w_tx_slot      = MSB_FIRST ? (LAST - r_tx_cnt) : r_tx_cnt;
    assign data_out_ready = (r_state == TX_SHIFT);
    assign out_bus        = data_out_ready ? r_tx_shift[w_tx_slot * BUS_W +: BUS_W] : '0;
    assign shift_done     = r_shift_done;

    // A push coinciding with the FSM pop is accepted by the FIFO, so it is not an overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (tx_push && w_tx_full && !w_tx_pop) begin
                r_err_overflow <= 1'b1;
            end
            if (rx_pop && w_rx_empty) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_serial_word_bridge.sv
// Bench for serial_word_bridge: 16-bit LSB-first, 16-bit MSB-first and 32-bit LSB-first instances.
module tb_serial_word_bridge;

    typedef struct packed {
        logic        eu;
        logic        eo;
        logic        txf;
        logic        rxv;
        logic        sd;
        logic        dor;
        logic        dir;
        logic [7:0]  ob;
        logic [31:0] rxw;
    } obs_t;

    typedef struct {
        logic [7:0]  inb;
        logic        adr;
        logic        arr;
        logic        rxp;
        logic        txp;
        logic [31:0] txw;
    } drv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    drv_t dr [3];
    obs_t o0, o1, o2;

    always #5 clk = ~clk;

    logic [7:0]  d0_ob, d1_ob, d2_ob;
    logic        d0_dir, d1_dir, d2_dir, d0_dor, d1_dor, d2_dor, d0_sd, d1_sd, d2_sd;
    logic        d0_rxv, d1_rxv, d2_rxv, d0_txf, d1_txf, d2_txf;
    logic        d0_eo, d1_eo, d2_eo, d0_eu, d1_eu, d2_eu;
    logic [15:0] d0_rxw, d1_rxw;
    logic [31:0] d2_rxw;

    assign o0 = {d0_eu, d0_eo, d0_txf, d0_rxv, d0_sd, d0_dor, d0_dir, d0_ob, 16'h0, d0_rxw};
    assign o1 = {d1_eu, d1_eo, d1_txf, d1_rxv, d1_sd, d1_dor, d1_dir, d1_ob, 16'h0, d1_rxw};
    assign o2 = {d2_eu, d2_eo, d2_txf, d2_rxv, d2_sd, d2_dor, d2_dir, d2_ob, d2_rxw};

    serial_word_bridge #(.WORD_W(16), .BUS_W(8), .RX_DEPTH(4), .TX_DEPTH(4), .MSB_FIRST(1'b0)) u_d0 (
        .clk(clk), .rst(rst), .in_bus(dr[0].inb), .ard_data_ready(dr[0].adr),
        .data_in_ready(d0_dir), .out_bus(d0_ob), .data_out_ready(d0_dor),
        .ard_receive_ready(dr[0].arr), .shift_done(d0_sd), .rx_word(d0_rxw), .rx_valid(d0_rxv),
        .rx_pop(dr[0].rxp), .tx_word(dr[0].txw[15:0]), .tx_push(dr[0].txp), .tx_full(d0_txf),
        .err_overflow(d0_eo), .err_underflow(d0_eu));

    serial_word_bridge #(.WORD_W(16), .BUS_W(8), .RX_DEPTH(4), .TX_DEPTH(4), .MSB_FIRST(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .in_bus(dr[1].inb), .ard_data_ready(dr[1].adr),
        .data_in_ready(d1_dir), .out_bus(d1_ob), .data_out_ready(d1_dor),
        .ard_receive_ready(dr[1].arr), .shift_done(d1_sd), .rx_word(d1_rxw), .rx_valid(d1_rxv),
        .rx_pop(dr[1].rxp), .tx_word(dr[1].txw[15:0]), .tx_push(dr[1].txp), .tx_full(d1_txf),
        .err_overflow(d1_eo), .err_underflow(d1_eu));

    serial_word_bridge #(.WORD_W(32), .BUS_W(8), .RX_DEPTH(4), .TX_DEPTH(4), .MSB_FIRST(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .in_bus(dr[2].inb), .ard_data_ready(dr[2].adr),
        .data_in_ready(d2_dir), .out_bus(d2_ob), .data_out_ready(d2_dor),
        .ard_receive_ready(dr[2].arr), .shift_done(d2_sd), .rx_word(d2_rxw), .rx_valid(d2_rxv),
        .rx_pop(dr[2].rxp), .tx_word(dr[2].txw), .tx_push(dr[2].txp), .tx_full(d2_txf),
        .err_overflow(d2_eo), .err_underflow(d2_eu));

    function automatic obs_t obs(input int d);
        case (d)
            0:       return o0;
            1:       return o1;
            default: return o2;
        endcase
    endfunction

    function automatic int beats_of(input int d);
        return (d == 2) ? 4 : 2;
    endfunction

    function automatic logic [31:0] msk(input int d);
        return (d == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // i-th beat on the wire for word w: byte i (LSB first) or byte n-1-i (MSB first).
    function automatic logic [31:0] beat_of(input int d, input logic [31:0] w, input int i);
        int n = beats_of(d);
        int k = (d == 1) ? (n - 1 - i) : i;
        return (w >> (8 * k)) & 32'hFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_drv();
        for (int d = 0; d < 3; d++) begin
            dr[d].inb = 8'h00;
            dr[d].adr = 1'b0;
            dr[d].arr = 1'b0;
            dr[d].rxp = 1'b0;
            dr[d].txp = 1'b0;
            dr[d].txw = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_drv();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_beat(input int d, input logic [7:0] b);
        int n = 0;
        dr[d].inb = b;
        dr[d].adr = 1'b1;
        while (!obs(d).dir && n < 50) begin
            tick();
            n++;
        end
        chk("rx_accept_timeout", 32'(n < 50), 32'd1);
        tick();
        dr[d].adr = 1'b0;
    endtask

    task automatic send_word(input int d, input logic [31:0] w);
        for (int i = 0; i < beats_of(d); i++) send_beat(d, 8'(beat_of(d, w, i)));
    endtask

    task automatic pop_check(input int d, input logic [31:0] w, input string tag);
        chk({tag, "_valid"}, 32'(obs(d).rxv), 32'd1);
        chk(tag, obs(d).rxw, w);
        dr[d].rxp = 1'b1;
        tick();
        dr[d].rxp = 1'b0;
    endtask

    task automatic push_word(input int d, input logic [31:0] w);
        dr[d].txw = w;
        dr[d].txp = 1'b1;
        tick();
        dr[d].txp = 1'b0;
    endtask

    task automatic wait_dor(input int d);
        int n = 0;
        while (!obs(d).dor && n < 20) begin
            tick();
            n++;
        end
        chk("tx_valid_timeout", 32'(n < 20), 32'd1);
    endtask

    task automatic recv_word(input int d, input logic [31:0] w, input string tag);
        dr[d].arr = 1'b1;
        for (int i = 0; i < beats_of(d); i++) begin
            wait_dor(d);
            chk(tag, 32'(obs(d).ob), beat_of(d, w, i));
            tick();
        end
        chk({tag, "_shift_done"}, 32'(obs(d).sd), 32'd1);
        dr[d].arr = 1'b0;
    endtask

    task automatic rand_run(input int d, input int nwords);
        logic [7:0]  rx_bytes [$];
        logic [31:0] rx_src [$];
        logic [31:0] rx_exp [$];
        logic [7:0]  tx_beats [$];
        int          nb = beats_of(d);
        int          cur = 0;
        int          tx_left = nwords;
        int          sd_cnt = 0;
        int          cyc = 0;
        logic        acc_rx, acc_tx, do_pop, do_push;
        logic [31:0] w, tw;
        obs_t        s;
        for (int k = 0; k < nwords; k++) begin
            w = $urandom() & msk(d);
            rx_src.push_back(w);
            for (int i = 0; i < nb; i++) rx_bytes.push_back(8'(beat_of(d, w, i)));
        end
        while (cyc < 3000 && (rx_bytes.size() > 0 || rx_exp.size() > 0 ||
                              tx_beats.size() > 0 || tx_left > 0)) begin
            s = obs(d);
            chk("rnd_rx_valid", 32'(s.rxv), 32'(rx_exp.size() != 0));
            chk("rnd_rx_ready", 32'(s.dir), 32'(!(cur == nb - 1 && rx_exp.size() == 4)));
            dr[d].adr = (rx_bytes.size() > 0) && ($urandom_range(0, 3) != 0);
            dr[d].inb = (rx_bytes.size() > 0) ? rx_bytes[0] : 8'h00;
            do_pop = (rx_exp.size() > 0) && ($urandom_range(0, 2) == 0);
            dr[d].rxp = do_pop;
            if (do_pop) chk("rnd_rx_word", s.rxw, rx_exp[0]);
            do_push = (tx_left > 0) && !s.txf && ($urandom_range(0, 1) == 0);
            tw = $urandom() & msk(d);
            dr[d].txp = do_push;
            dr[d].txw = tw;
            dr[d].arr = ($urandom_range(0, 2) != 0);
            acc_rx = dr[d].adr && s.dir;
            acc_tx = dr[d].arr && s.dor;
            if (acc_tx) begin
                if (tx_beats.size() == 0) chk("rnd_tx_extra_beat", 32'(s.dor), 32'd0);
                else chk("rnd_tx_beat", 32'(s.ob), 32'(tx_beats[0]));
            end
            tick();
            if (acc_rx) begin
                void'(rx_bytes.pop_front());
                cur++;
                if (cur == nb) begin
                    cur = 0;
                    rx_exp.push_back(rx_src.pop_front());
                end
            end
            if (do_pop) void'(rx_exp.pop_front());
            if (do_push) begin
                tx_left--;
                for (int i = 0; i < nb; i++) tx_beats.push_back(8'(beat_of(d, tw, i)));
            end
            if (acc_tx && tx_beats.size() > 0) void'(tx_beats.pop_front());
            if (obs(d).sd) sd_cnt++;
            cyc++;
        end
        clear_drv();
        chk("rnd_timeout", 32'(cyc < 3000), 32'd1);
        chk("rnd_shift_done_count", 32'(sd_cnt), 32'(nwords));
        chk("rnd_no_errors", {30'h0, obs(d).eo, obs(d).eu}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rx_b [4];
        logic [31:0] exp_w;
        int          unstable;
        int          sd_seen;
        obs_t        s;

        clear_drv();
        do_reset();

        // Reset values on every instance.
        for (int d = 0; d < 3; d++) begin
            s = obs(d);
            chk("rst_data_in_ready", 32'(s.dir), 32'd1);
            chk("rst_data_out_ready", 32'(s.dor), 32'd0);
            chk("rst_out_bus", 32'(s.ob), 32'd0);
            chk("rst_shift_done", 32'(s.sd), 32'd0);
            chk("rst_rx_valid", 32'(s.rxv), 32'd0);
            chk("rst_rx_word", s.rxw, 32'd0);
            chk("rst_tx_full", 32'(s.txf), 32'd0);
            chk("rst_err", {30'h0, s.eo, s.eu}, 32'd0);
        end

        // Byte order: 0x34 then 0x12 (then 0x78, 0x56 for the 32-bit instance).
        rx_b[0] = 8'h34;
        rx_b[1] = 8'h12;
        rx_b[2] = 8'h78;
        rx_b[3] = 8'h56;
        for (int d = 0; d < 3; d++) begin
            exp_w = 32'h0;
            for (int i = 0; i < beats_of(d); i++) begin
                send_beat(d, rx_b[i]);
                exp_w |= 32'(rx_b[i]) << (8 * ((d == 1) ? (beats_of(d) - 1 - i) : i));
            end
            pop_check(d, exp_w, "rx_order");
            chk("rx_order_drained", 32'(obs(d).rxv), 32'd0);
        end

        // RX backpressure: four words fill the FIFO, last byte of the fifth stalls until a pop.
        for (int k = 1; k <= 4; k++) send_word(0, 32'hA000 + 32'(k) * 32'h0111);
        chk("bp_first_byte_ready", 32'(obs(0).dir), 32'd1);
        send_beat(0, 8'(beat_of(0, 32'hA555, 0)));
        chk("bp_last_byte_blocked", 32'(obs(0).dir), 32'd0);
        dr[0].inb = 8'(beat_of(0, 32'hA555, 1));
        dr[0].adr = 1'b1;
        chk("bp_head_word1", obs(0).rxw, 32'hA111);
        dr[0].rxp = 1'b1;
        tick();
        dr[0].rxp = 1'b0;
        chk("bp_ready_after_pop", 32'(obs(0).dir), 32'd1);
        tick();
        dr[0].adr = 1'b0;
        for (int k = 2; k <= 5; k++) pop_check(0, 32'hA000 + 32'(k) * 32'h0111, "bp_order");
        chk("bp_drained", 32'(obs(0).rxv), 32'd0);

        // TX: two-cycle latency, stall holds the beat, single shift_done pulse.
        push_word(0, 32'hBEEF);
        chk("tx_lat_cycle1", 32'(obs(0).dor), 32'd0);
        tick();
        chk("tx_lat_cycle2", 32'(obs(0).dor), 32'd0);
        tick();
        chk("tx_lat_valid", 32'(obs(0).dor), 32'd1);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (obs(0).ob !== 8'hEF || obs(0).dor !== 1'b1) unstable++;
            tick();
        end
        chk("tx_stall_stable", 32'(unstable), 32'd0);
        chk("tx_stall_beat0", 32'(obs(0).ob), 32'hEF);
        dr[0].arr = 1'b1;
        tick();
        chk("tx_beat1", 32'(obs(0).ob), 32'hBE);
        chk("tx_no_early_done", 32'(obs(0).sd), 32'd0);
        tick();
        dr[0].arr = 1'b0;
        chk("tx_shift_done", 32'(obs(0).sd), 32'd1);
        chk("tx_back_idle", 32'(obs(0).dor), 32'd0);
        tick();
        chk("tx_shift_done_single", 32'(obs(0).sd), 32'd0);

        // Overflow: one word held in the stalled shifter, four fill the FIFO, the next is dropped.
        push_word(0, 32'h1111);
        wait_dor(0);
        for (int k = 2; k <= 5; k++) push_word(0, 32'(k) * 32'h1111);
        chk("ovf_full", 32'(obs(0).txf), 32'd1);
        chk("ovf_not_yet", 32'(obs(0).eo), 32'd0);
        push_word(0, 32'h6666);
        chk("ovf_flag", 32'(obs(0).eo), 32'd1);
        for (int k = 1; k <= 5; k++) recv_word(0, 32'(k) * 32'h1111, "ovf_drain");
        dr[0].arr = 1'b1;
        sd_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (obs(0).dor) sd_seen++;
            tick();
        end
        dr[0].arr = 1'b0;
        chk("ovf_dropped_never_sent", 32'(sd_seen), 32'd0);

        // Underflow: pop on an empty RX FIFO.
        chk("udf_empty", 32'(obs(0).rxv), 32'd0);
        dr[0].rxp = 1'b1;
        tick();
        dr[0].rxp = 1'b0;
        chk("udf_flag", 32'(obs(0).eu), 32'd1);
        chk("udf_still_empty", 32'(obs(0).rxv), 32'd0);
        chk("ovf_sticky", 32'(obs(0).eo), 32'd1);

        // Asynchronous reset in the middle of an RX word and a TX word.
        for (int j = 0; j < 2; j++) begin
            int d = 2 * j;
            do_reset();
            for (int i = 0; i < beats_of(d) / 2; i++) send_beat(d, 8'hEE);
            push_word(d, 32'hCAFE_F00D & msk(d));
            wait_dor(d);
            dr[d].arr = 1'b1;
            tick();
            dr[d].arr = 1'b0;
            #2 rst = 1'b1;
            #1;
            chk("arst_data_out_ready", 32'(obs(d).dor), 32'd0);
            chk("arst_data_in_ready", 32'(obs(d).dir), 32'd1);
            chk("arst_errs", {30'h0, obs(d).eo, obs(d).eu}, 32'd0);
            #1 rst = 1'b0;
            sd_seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (obs(d).sd || obs(d).dor || obs(d).rxv) sd_seen++;
            end
            chk("arst_quiet", 32'(sd_seen), 32'd0);
            exp_w = 32'h1357_9BDF & msk(d);
            send_word(d, exp_w);
            pop_check(d, exp_w, "arst_rx_word");
            exp_w = 32'h2468_ACE0 & msk(d);
            push_word(d, exp_w);
            recv_word(d, exp_w, "arst_tx_word");
        end

        // Randomised traffic against the queue model on every instance.
        for (int d = 0; d < 3; d++) begin
            do_reset();
            rand_run(d, 24);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
